// File: rtl/rst_generator_pkg.sv
// Shared constants and encodings for the reset sequencer.
package rst_generator_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_STRETCH_CYCLES  = 32;
  localparam int unsigned DEF_CORE_DELAY      = 4;
  localparam int unsigned DEF_CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'b00,
    ST_CORE_WAIT = 2'b01,
    ST_RUN       = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_EXT = 2'b01,
    CAUSE_SW  = 2'b10
  } cause_e;

endpackage

// File: rtl/rst_generator_sync_debounce.sv
// Push-button path: 2-flop synchronizer followed by a saturating debounce counter.
// act_c is high while the synced input has been high DEBOUNCE_CYCLES consecutive cycles.
module rst_generator_sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic act_c
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic [DB_W-1:0] db_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      // any synced low restarts the qualification window
      if (!sync2_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q != DB_LAST) begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  assign act_c = sync2_q && (db_cnt_q == DB_LAST);

endmodule

// File: rtl/rst_generator.sv
// Reset sequencer: merges POR, debounced button and software requests; releases the
// bus reset after a stretch and the core reset CORE_DELAY bus cycles later.
module rst_generator
  import rst_generator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STRETCH_CYCLES  = DEF_STRETCH_CYCLES,
  parameter int unsigned CORE_DELAY      = DEF_CORE_DELAY,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ext_rst_i,
  input  logic       sw_rst_i,
  output logic       rst_bus_o,
  output logic       rst_core_o,
  output logic [1:0] rst_cause_o,
  output logic       rst_done_o
);

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST    = CNT_W'(CORE_DELAY - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ext_act_c;

  rst_generator_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(ext_rst_i),
    .act_c  (ext_act_c)
  );

  // rst_i has its own branch, so inside the else only EXT and SW can be active
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      rst_bus_o   <= 1'b1;
      rst_core_o  <= 1'b1;
      rst_cause_o <= CAUSE_POR;
      rst_done_o  <= 1'b0;
    end else begin
      rst_done_o <= 1'b0;
      if (ext_act_c || sw_rst_i) begin
        state_q     <= ST_HOLD;
        cnt_q       <= '0;
        rst_bus_o   <= 1'b1;
        rst_core_o  <= 1'b1;
        rst_cause_o <= ext_act_c ? CAUSE_EXT : CAUSE_SW;
      end else begin
        case (state_q)
          ST_HOLD: begin
            if (cnt_q == STRETCH_LAST) begin
              state_q   <= ST_CORE_WAIT;
              cnt_q     <= '0;
              rst_bus_o <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_CORE_WAIT: begin
            if (cnt_q == CORE_LAST) begin
              state_q    <= ST_RUN;
              cnt_q      <= '0;
              rst_core_o <= 1'b0;
              rst_done_o <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_RUN: begin
            cnt_q <= '0;
          end
          default: begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            rst_bus_o  <= 1'b1;
            rst_core_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_generator.sv
// Scenario bench for rst_generator: per-cycle expected outputs are queued, then popped and compared.
module tb_rst_generator;

  localparam int STRETCH = 32;
  localparam int CDLY    = 4;
  localparam logic [1:0] C_POR = 2'b00;
  localparam logic [1:0] C_EXT = 2'b01;
  localparam logic [1:0] C_SW  = 2'b10;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       ext_rst_i;
  logic       sw_rst_i;
  logic       rst_bus_o;
  logic       rst_core_o;
  logic [1:0] rst_cause_o;
  logic       rst_done_o;

  int         ntests = 0;
  int         nfail  = 0;
  logic [4:0] sb[$];

  always #5 clk = ~clk;

  rst_generator dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .ext_rst_i  (ext_rst_i),
    .sw_rst_i   (sw_rst_i),
    .rst_bus_o  (rst_bus_o),
    .rst_core_o (rst_core_o),
    .rst_cause_o(rst_cause_o),
    .rst_done_o (rst_done_o)
  );

  function automatic logic [4:0] ev(input logic b, input logic c, input logic d, input logic [1:0] ca);
    return {b, c, d, ca};
  endfunction

  function automatic logic [4:0] obs();
    return {rst_bus_o, rst_core_o, rst_done_o, rst_cause_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [4:0] v);
    repeat (n) sb.push_back(v);
  endtask

  // k = edges since the first edge with every source inactive
  task automatic push_rel(input int k0, input int k1, input logic [1:0] ca);
    for (int k = k0; k <= k1; k++)
      sb.push_back(ev(k < STRETCH, k < STRETCH + CDLY, k == STRETCH + CDLY, ca));
  endtask

  task automatic test_reset();
    logic [4:0] e;
    rst_i = 1'b1; ext_rst_i = 1'b0; sw_rst_i = 1'b0;
    push_n(5, ev(1, 1, 0, C_POR));
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL reset_state: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    rst_i = 1'b0;
    push_rel(1, 40, C_POR);
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL por_release: bus/core/done/cause got %b expected %b", obs(), e); end
    end
  endtask

  task automatic test_glitch();
    logic [4:0] e;
    ext_rst_i = 1'b1;
    push_n(10, ev(0, 0, 0, C_POR));
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL ext_glitch_high: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    ext_rst_i = 1'b0;
    push_n(8, ev(0, 0, 0, C_POR));
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL ext_glitch_low: bus/core/done/cause got %b expected %b", obs(), e); end
    end
  endtask

  task automatic test_button();
    logic [4:0] e;
    ext_rst_i = 1'b1;
    push_n(17, ev(0, 0, 0, C_POR));
    push_n(23, ev(1, 1, 0, C_EXT));
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL button_press: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    ext_rst_i = 1'b0;
    push_n(2, ev(1, 1, 0, C_EXT));
    push_rel(1, 40, C_EXT);
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL button_release: bus/core/done/cause got %b expected %b", obs(), e); end
    end
  endtask

  task automatic test_sw();
    logic [4:0] e;
    sw_rst_i = 1'b1;
    push_n(1, ev(1, 1, 0, C_SW));
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL sw_assert: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    sw_rst_i = 1'b0;
    push_rel(1, 40, C_SW);
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL sw_release: bus/core/done/cause got %b expected %b", obs(), e); end
    end
  endtask

  task automatic test_retrigger();
    logic [4:0] e;
    int ndone = 0;
    sw_rst_i = 1'b1;
    push_n(1, ev(1, 1, 0, C_SW));
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL retrig_first: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    sw_rst_i = 1'b0;
    push_rel(1, STRETCH + 2, C_SW);
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (rst_done_o === 1'b1) ndone++;
      if (obs() !== e) begin nfail++; $display("FAIL retrig_partial: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    sw_rst_i = 1'b1;
    push_n(1, ev(1, 1, 0, C_SW));
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL retrig_reassert: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    sw_rst_i = 1'b0;
    push_rel(1, 40, C_SW);
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (rst_done_o === 1'b1) ndone++;
      if (obs() !== e) begin nfail++; $display("FAIL retrig_restart: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    ntests++;
    if (ndone !== 1) begin nfail++; $display("FAIL retrig_done_count: got %0d pulses expected 1", ndone); end
  endtask

  task automatic test_priority();
    logic [4:0] e;
    rst_i = 1'b1; sw_rst_i = 1'b1;
    push_n(1, ev(1, 1, 0, C_POR));
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL prio_por_sw: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    rst_i = 1'b0; sw_rst_i = 1'b0;
    push_rel(1, 10, C_POR);
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL prio_hold: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    rst_i = 1'b1;
    push_n(1, ev(1, 1, 0, C_POR));
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL por_mid_hold: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    rst_i = 1'b0;
    push_rel(1, 5, C_POR);
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL por_restart: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    sw_rst_i = 1'b1;
    push_n(1, ev(1, 1, 0, C_SW));
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL sw_in_hold: bus/core/done/cause got %b expected %b", obs(), e); end
    end
    sw_rst_i = 1'b0;
    push_rel(1, 40, C_SW);
    while (sb.size() != 0) begin
      tick(); e = sb.pop_front(); ntests++;
      if (obs() !== e) begin nfail++; $display("FAIL sw_hold_release: bus/core/done/cause got %b expected %b", obs(), e); end
    end
  endtask

  initial begin
    rst_i = 1'b1; ext_rst_i = 1'b0; sw_rst_i = 1'b0;
    test_reset();
    test_glitch();
    test_button();
    test_sw();
    test_retrigger();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
